data_memory_responder: RTL and testbench

Handshaked data-memory responder: the target side of the core's load/store port. Accepts one request at a time on a valid/ready channel, applies a configurable number of wait states, performs a byte/half/word write or a word read, and returns the result on a valid/ready response channel with an error flag. It replaces the zero-latency data memory when the core moves to a stalling memory interface.

---
 rtl/data_memory_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder
// Target side of the core's load/store port. One request at a time is
// accepted on a valid/ready channel. After Latency wait cycles the block
// performs a byte/half/word write or a word read, then holds the result on a
// valid/ready response channel until it is consumed.
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word
// accesses as errors. Without it, the low address bits are ignored for those
// access sizes.
//
// Storage is deliberately left out of reset and comes up with undefined
// contents.

module data_memory_responder #(
  parameter int RegBits = 32,
  parameter int Depth   = 1024,
  parameter int Latency = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [RegBits-1:0] req_addr_i,
  input  logic [1:0]         req_we_i,
  input  logic [RegBits-1:0] req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [RegBits-1:0] rsp_rdata_o,
  output logic               rsp_err_o
);

  localparam int         IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int         Lanes  = RegBits / 8;
  localparam logic [3:0] LatCnt = 4'(Latency);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte-lane write enables for an access of size we at byte offset lo.
  // A half access selects the lane pair named by lo[1], which also makes
  // lo[0] irrelevant when alignment is not enforced.
  function automatic logic [Lanes-1:0] lane_mask(input logic [1:0] we,
                                                 input logic [1:0] lo);
    logic [Lanes-1:0] m;
    m = '0;
    for (int l = 0; l < Lanes; l++) begin
      case (we)
        2'b01:   m[l] = (l[1:0] == lo);
        2'b10:   m[l] = (l[1] == lo[1]);
        2'b11:   m[l] = 1'b1;
        default: m[l] = 1'b0;
      endcase
    end
    return m;
  endfunction

  // Spread right-aligned write data across every lane so the lane mask
  // alone decides what lands in storage.
  function automatic logic [RegBits-1:0] lane_data(input logic [1:0]         we,
                                                   input logic [RegBits-1:0] wd);
    logic [RegBits-1:0] d;
    case (we)
      2'b01:   d = {Lanes{wd[7:0]}};
      2'b10:   d = {(Lanes / 2){wd[15:0]}};
      2'b11:   d = wd;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Alignment fault for the access size; reads are whole-word accesses.
  function automatic logic misaligned(input logic [1:0] we,
                                      input logic [1:0] lo);
    logic bad;
    case (we)
      2'b01:   bad = 1'b0;
      2'b10:   bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  logic [RegBits-1:0] mem [Depth];

  state_t             state_r;
  state_t             state_nxt_s;
  logic [3:0]         cnt_r;
  logic [RegBits-1:0] addr_r;
  logic [1:0]         we_r;
  logic [RegBits-1:0] wdata_r;
  logic               rsp_valid_r;
  logic [RegBits-1:0] rsp_rdata_r;
  logic               rsp_err_r;

  logic               req_ready_s;
  logic               accept_s;
  logic               access_s;
  logic [RegBits-1:0] acc_addr_s;
  logic [1:0]         acc_we_s;
  logic [RegBits-1:0] acc_wdata_s;
  logic [IdxW-1:0]    idx_s;
  logic               range_err_s;
  logic               align_err_s;
  logic               err_s;
  logic [Lanes-1:0]   wmask_s;
  logic [RegBits-1:0] wlane_s;
  logic [RegBits-1:0] rdata_s;

  // State register: reset forces IDLE, dropping any in-flight request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (LatCnt == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake, access strobe and access operands. With zero latency the
  // access uses the live request; otherwise it uses the captured copy.
  always_comb begin
    req_ready_s = (state_r == ST_IDLE) && rst_i;
    accept_s    = req_valid_i && req_ready_s;
    access_s    = (accept_s && (LatCnt == 4'd0)) ||
                  ((state_r == ST_WAIT) && (cnt_r <= 4'd1));
    if (state_r == ST_IDLE) begin
      acc_addr_s  = req_addr_i;
      acc_we_s    = req_we_i;
      acc_wdata_s = req_wdata_i;
    end else begin
      acc_addr_s  = addr_r;
      acc_we_s    = we_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Address decode, error detection, lane selection and read data.
  always_comb begin
    idx_s       = acc_addr_s[IdxW+1:2];
    range_err_s = (acc_addr_s[RegBits-1:2] >= (RegBits-2)'(Depth));
`ifdef DMEM_MISALIGN_CHECK_EN
    align_err_s = misaligned(acc_we_s, acc_addr_s[1:0]);
`else
    align_err_s = 1'b0;
`endif
    err_s   = range_err_s || align_err_s;
    wmask_s = lane_mask(acc_we_s, acc_addr_s[1:0]);
    wlane_s = lane_data(acc_we_s, acc_wdata_s);
    if (!err_s && (acc_we_s == 2'b00)) begin
      rdata_s = mem[idx_s];
    end else begin
      rdata_s = '0;
    end
  end

  // Request capture, wait counter and registered response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r       <= 4'd0;
      addr_r      <= '0;
      we_r        <= 2'b00;
      wdata_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r  <= req_addr_i;
        we_r    <= req_we_i;
        wdata_r <= req_wdata_i;
        cnt_r   <= LatCnt;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (access_s) begin
        rsp_valid_r <= 1'b1;
        rsp_rdata_r <= rdata_s;
        rsp_err_r   <= err_s;
      end else if ((state_r == ST_RESP) && rsp_ready_i) begin
        rsp_valid_r <= 1'b0;
        rsp_rdata_r <= '0;
        rsp_err_r   <= 1'b0;
      end
    end
  end

  // Storage write: only on the single access edge of a non-faulting write.
  always_ff @(posedge clk_i) begin
    if (access_s && !err_s && rst_i) begin
      for (int l = 0; l < Lanes; l++) begin
        if (wmask_s[l]) begin
          mem[idx_s][l*8 +: 8] <= wlane_s[l*8 +: 8];
        end
      end
    end
  end

  assign req_ready_o = req_ready_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (Latency = 2, Depth = 1024).
// The stimulus pushes expected responses; an independent monitor checks them.
module tb_data_memory_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_we = 2'b00;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];
  logic prev_valid = 1'b0;

  data_memory_responder #(.RegBits(32), .Depth(1024), .Latency(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: latency on the first valid cycle, data/err on the handshake.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (q.size() == 0) begin
        if (!prev_valid) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: actual rdata %h err %b required no response", rsp_rdata, rsp_err);
        end
      end else begin
        if (!prev_valid) check("rsp_latency", 32'(cyc), 32'(q[0].cyc));
        if (rsp_ready) begin
          check("rsp_rdata", rsp_rdata, q[0].rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
          void'(q.pop_front());
        end
      end
    end
    prev_valid <= rsp_valid && !rsp_ready && rst;
  end

  // Issue one request (call at posedge+1); returns just after acceptance.
  task automatic do_req(input logic [31:0] a, input logic [1:0] we, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input bit push, output int acc_cyc);
    int   t;
    exp_t e;
    t = 0;
    req_addr = a; req_we = we; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: actual not accepted required accept of addr %h", a);
      req_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (push) begin
      e.rdata = er; e.err = ee; e.cyc = cyc + LAT;
      q.push_back(e);
    end
    // Scramble inputs: only the acceptance edge may matter.
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_we = ~we;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] we, input logic [31:0] wd);
    int c;
    do_req(a, we, wd, 32'h0, 1'b0, 1'b1, c);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] er, input logic ee);
    int c;
    do_req(a, 2'b00, 32'h5555_AAAA, er, ee, 1'b1, c);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d pending required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp10;
    logic [31:0] held;
    int          acc;
    int          rise;
    int          t;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'h1);
    check("reset_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_err", {31'b0, rsp_err}, 32'h0);
    @(posedge clk);
    #1;

    // Word write/read
    wr(32'h10, 2'b11, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, 1'b0);
    // Byte write into a cleared word (upper wdata bits must be ignored)
    wr(32'h10, 2'b11, 32'h0);
    wr(32'h12, 2'b01, 32'hFFFF_FFA5);
    rd(32'h10, 32'h00A5_0000, 1'b0);
    // Misaligned half write
`ifdef DMEM_MISALIGN_CHECK_EN
    do_req(32'h11, 2'b10, 32'hFFFF_1234, 32'h0, 1'b1, 1'b1, acc);
    exp10 = 32'h00A5_0000;
`else
    wr(32'h11, 2'b10, 32'hFFFF_1234);
    exp10 = 32'h00A5_1234;
`endif
    rd(32'h10, exp10, 1'b0);
    // Byte write to top lane
    wr(32'h13, 2'b01, 32'h0000_0077);
    exp10 = {8'h77, exp10[23:0]};
    rd(32'h10, exp10, 1'b0);
    // Upper half write
    wr(32'h14, 2'b11, 32'h1111_1111);
    wr(32'h16, 2'b10, 32'h0000_BEEF);
    rd(32'h14, 32'hBEEF_1111, 1'b0);
    // Out of range: error, no write, no aliasing onto word 0
    wr(32'h0, 2'b11, 32'hCAFE_F00D);
    do_req(32'h1000, 2'b11, 32'h1234_5678, 32'h0, 1'b1, 1'b1, acc);
    rd(32'h0, 32'hCAFE_F00D, 1'b0);
    rd(32'h1000, 32'h0, 1'b1);
    // Last valid word
    wr(32'hFFC, 2'b11, 32'h0BAD_C0DE);
    rd(32'hFFC, 32'h0BAD_C0DE, 1'b0);
    drain();

    // Back-pressure
    rsp_ready = 1'b0;
    rd(32'h10, exp10, 1'b0);
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", {31'b0, rsp_valid}, 32'h1);
    held = rsp_rdata;
    check("bp_rdata", held, exp10);
    req_addr = 32'h14; req_we = 2'b00; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_hold", {31'b0, rsp_valid}, 32'h1);
      check("bp_rdata_hold", rsp_rdata, exp10);
      check("bp_ready_low", {31'b0, req_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    rise = cyc;
    do_req(32'h14, 2'b00, 32'h0, 32'hBEEF_1111, 1'b0, 1'b1, acc);
    check("bp_accept_edge", 32'(acc), 32'(rise + 2));
    drain();

    // Reset during WAIT drops the write and its response
    wr(32'h20, 2'b11, 32'h0101_0101);
    drain();
    do_req(32'h20, 2'b11, 32'h5A5A_5A5A, 32'h0, 1'b0, 1'b0, acc);
    rst = 1'b0;
    #1;
    check("abort_ready_low", {31'b0, req_ready}, 32'h0);
    check("abort_valid_low", {31'b0, rsp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_rsp", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    rd(32'h20, 32'h0101_0101, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
